// File: rtl/shake256_pkg.sv
// Shared types and constants for the SHAKE256 stream sequencer: block geometry,
// core length codes, the sequencer state set and the last-word mask helper.
package shake256_pkg;

   localparam int WORD_W = 64;
   localparam int RATE   = 1088;
   localparam int WPB    = RATE / WORD_W;

   typedef logic [10:0]       core_len_t;
   typedef logic [RATE-1:0]   block_t;
   typedef logic [WORD_W-1:0] word_t;

   localparam core_len_t LEN_NONFINAL = 11'd1089;

   typedef enum logic [2:0] {IDLE, FILL, ISSUE, SQUEEZE, DRAIN, DONE} state_e;

   // Keeps the top nbits of a word; 0 clears it, 64 or more keeps all of it.
   function automatic word_t mask_last(input word_t data, input logic [6:0] nbits);
      return data & ~({WORD_W{1'b1}} >> nbits);
   endfunction

endpackage

// File: rtl/shake256_stream_ctrl_if.sv
// Stream, status and core-side signals of the sequencer; slave is the
// sequencer's view, master is the environment (producer, consumer and core).
interface shake256_stream_ctrl_if #(parameter int OUTW_W = 16);
   import shake256_pkg::*;

   logic              start;
   logic [OUTW_W-1:0] out_words;
   logic              in_valid;
   logic              in_ready;
   word_t             in_data;
   logic              in_last;
   logic [6:0]        in_bits;
   logic              out_valid;
   logic              out_ready;
   word_t             out_data;
   logic              busy;
   logic              done;
   logic              overrun;
   logic              core_reset_n;
   logic              core_load;
   block_t            core_message;
   core_len_t         core_length;
   logic              core_busy;
   logic              core_squeezed;
   block_t            core_hash;

   modport slave (
      input  start, out_words, in_valid, in_data, in_last, in_bits, out_ready,
             core_busy, core_squeezed, core_hash,
      output in_ready, out_valid, out_data, busy, done, overrun,
             core_reset_n, core_load, core_message, core_length
   );

   modport master (
      output start, out_words, in_valid, in_data, in_last, in_bits, out_ready,
             core_busy, core_squeezed, core_hash,
      input  in_ready, out_valid, out_data, busy, done, overrun,
             core_reset_n, core_load, core_message, core_length
   );

endinterface

// File: rtl/shake256_block_packer.sv
// Packs 64-bit words MSB-first into one rate block, counting words and message
// bits; the last word of a message is truncated to its valid leading bits.
module shake256_block_packer
   import shake256_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       wr_en,
   input  word_t      wr_data,
   input  logic       wr_last,
   input  logic [6:0] wr_bits,
   output block_t     block,
   output logic [4:0] wcnt,
   output core_len_t  wr_len
);

   block_t     block_q, block_d;
   logic [4:0] wcnt_q, wcnt_d;
   core_len_t  bitcnt_q, bitcnt_d;
   core_len_t  add_bits;

   always_comb begin
      add_bits = wr_last ? ((wr_bits > 7'd64) ? 11'd64 : core_len_t'(wr_bits)) : 11'd64;
      wr_len   = bitcnt_q + add_bits;
      block_d  = block_q;
      wcnt_d   = wcnt_q;
      bitcnt_d = bitcnt_q;
      if (clear) begin
         block_d  = '0;
         wcnt_d   = '0;
         bitcnt_d = '0;
      end else if (wr_en) begin
         for (int k = 0; k < WPB; k++) begin
            if (wcnt_q == 5'(k))
               block_d[RATE-1-WORD_W*k -: WORD_W] = wr_last ? mask_last(wr_data, wr_bits) : wr_data;
         end
         wcnt_d   = wcnt_q + 5'd1;
         bitcnt_d = wr_len;
      end
   end

   // NOTE: the block buffer is reset like any control flop because it drives
   // core_message directly and must read as zero straight out of reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         block_q  <= '0;
         wcnt_q   <= '0;
         bitcnt_q <= '0;
      end else begin
         block_q  <= block_d;
         wcnt_q   <= wcnt_d;
         bitcnt_q <= bitcnt_d;
      end
   end

   assign block = block_q;
   assign wcnt  = wcnt_q;

endmodule

// File: rtl/shake256_stream_ctrl.sv
// SHAKE256 stream sequencer: feeds packed rate blocks to the core, then drains
// squeezed blocks as a counted stream of 64-bit output words.
module shake256_stream_ctrl
   import shake256_pkg::*;
#(
   parameter int OUTW_W = 16
) (
   input logic clock,
   input logic reset,
   shake256_stream_ctrl_if.slave bus
);

   state_e            state_q, state_d;
   logic [OUTW_W-1:0] rem_q, rem_d;
   logic [4:0]        ocnt_q, ocnt_d;
   logic [4:0]        oidx_q, oidx_d;
   block_t            obuf_q, obuf_d;
   logic              final_q, final_d;
   core_len_t         length_q, length_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic              core_reset_n_q, core_reset_n_d;

   logic       load_fire, pk_wr_en, pk_clear, hs_out;
   logic [4:0] pk_wcnt;
   core_len_t  pk_len;
   block_t     pk_block;
   word_t      out_word;

   // NOTE: the load strobe is combinational on core_busy so it fires in the very
   // cycle the core becomes free; a registered copy would act on stale busy.
   assign load_fire = (state_q == ISSUE) && !bus.core_busy;
   assign pk_wr_en  = in_ready_q && bus.in_valid;
   assign pk_clear  = (load_fire && !final_q) || (state_q == IDLE && bus.start);
   assign hs_out    = out_valid_q && bus.out_ready;

   shake256_block_packer u_packer (
      .clock   (clock),
      .reset   (reset),
      .clear   (pk_clear),
      .wr_en   (pk_wr_en),
      .wr_data (bus.in_data),
      .wr_last (bus.in_last),
      .wr_bits (bus.in_bits),
      .block   (pk_block),
      .wcnt    (pk_wcnt),
      .wr_len  (pk_len)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      ocnt_d    = ocnt_q;
      oidx_d    = oidx_q;
      obuf_d    = obuf_q;
      final_d   = final_q;
      length_d  = length_q;
      overrun_d = overrun_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            if (bus.out_words == '0) begin
               done_d = 1'b1;
            end else begin
               rem_d     = bus.out_words;
               overrun_d = 1'b0;
               state_d   = FILL;
            end
         end
         FILL: if (pk_wr_en) begin
            if (bus.in_last) begin
               final_d  = 1'b1;
               length_d = pk_len;
               state_d  = ISSUE;
            end else if (pk_wcnt == 5'(WPB-1)) begin
               final_d  = 1'b0;
               length_d = LEN_NONFINAL;
               state_d  = ISSUE;
            end
         end
         ISSUE: if (load_fire) state_d = final_q ? SQUEEZE : FILL;
         SQUEEZE: if (bus.core_squeezed) begin
            obuf_d  = bus.core_hash;
            ocnt_d  = (rem_q < OUTW_W'(WPB)) ? 5'(rem_q) : 5'(WPB);
            oidx_d  = '0;
            state_d = DRAIN;
         end
         DRAIN: begin
            // A block squeezed while still draining the previous one is lost.
            if (bus.core_squeezed) overrun_d = 1'b1;
            if (hs_out) begin
               oidx_d = oidx_q + 5'd1;
               if (rem_q != '0) rem_d = rem_q - OUTW_W'(1);
               if (rem_q <= OUTW_W'(1))          state_d = DONE;
               else if (oidx_q + 5'd1 == ocnt_q) state_d = SQUEEZE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      in_ready_d     = (state_d == FILL);
      out_valid_d    = (state_d == DRAIN);
      busy_d         = (state_d != IDLE);
      core_reset_n_d = (state_d != IDLE) && (state_d != DONE);
      done_d         = done_d || (state_d == DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         rem_q          <= '0;
         ocnt_q         <= '0;
         oidx_q         <= '0;
         obuf_q         <= '0;
         final_q        <= 1'b0;
         length_q       <= '0;
         in_ready_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         overrun_q      <= 1'b0;
         core_reset_n_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rem_q          <= rem_d;
         ocnt_q         <= ocnt_d;
         oidx_q         <= oidx_d;
         obuf_q         <= obuf_d;
         final_q        <= final_d;
         length_q       <= length_d;
         in_ready_q     <= in_ready_d;
         out_valid_q    <= out_valid_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         overrun_q      <= overrun_d;
         core_reset_n_q <= core_reset_n_d;
      end
   end

   always_comb begin
      out_word = '0;
      for (int k = 0; k < WPB; k++) begin
         if (oidx_q == 5'(k)) out_word = obuf_q[RATE-1-WORD_W*k -: WORD_W];
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = out_word;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.overrun      = overrun_q;
   assign bus.core_reset_n = core_reset_n_q;
   assign bus.core_load    = load_fire;
   assign bus.core_message = pk_block;
   assign bus.core_length  = length_q;

endmodule
